aes_decipher_ctrl: RTL and testbench

Iterative AES decryption sequencer. Accepts one 128-bit ciphertext block over a valid/ready handshake and performs the initial AddRoundKey with the last round key. It then runs the block through one shared non-last `inverse_round` instance once per middle round, and through one `LAST_ROUND=1` instance for the final round. The block fetches round keys by index from the key-schedule storage and presents the plaintext on a second valid/ready handshake. It sits between the decipher input stage and the output buffer, and owns the round-key read port while busy.

---
 rtl/aes_decipher_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_aes_decipher_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_ctrl.sv
// Iterative AES decryption sequencer: one inverse round per clock, round keys fetched by index
// from the external key schedule, valid/ready handshakes on both the ciphertext and plaintext sides.

package aes_package;
  localparam int DATA_WIDTH = 128;
endpackage

// One AES inverse cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module inverse_round #(
  parameter bit LAST_ROUND = 1'b0
) (
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  output logic [127:0] o_state
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (bb[0] ? aa : 8'h00);
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 by repeated squaring; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                               input logic [7:0] a2, input logic [7:0] a3);
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [7:0] w_sub [16];

  // Byte k is row k%4, column k/4; row r is rotated right by r columns.
  for (genvar k = 0; k < 16; k++) begin : g_sub
    localparam int ROW = k % 4;
    localparam int COL = k / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign w_sub[k] = inv_sbox(i_state[8*(15-SRC) +: 8]) ^ i_rk[8*(15-k) +: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    if (LAST_ROUND) begin : g_last
      assign o_state[127-32*c -: 32] = {w_sub[4*c], w_sub[4*c+1], w_sub[4*c+2], w_sub[4*c+3]};
    end else begin : g_mix
      assign o_state[127-32*c -: 32] = inv_mix_col(w_sub[4*c], w_sub[4*c+1], w_sub[4*c+2], w_sub[4*c+3]);
    end
  end

endmodule

module aes_decipher_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int DATA_WIDTH = aes_package::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  key_valid,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [3:0]            rk_idx,
  input  logic [DATA_WIDTH-1:0] rk_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy
);

  if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14) || DATA_WIDTH != 128) begin : g_bad_cfg
    $error("aes_decipher_ctrl: NUM_ROUNDS must be 10, 12 or 14 and DATA_WIDTH must be 128");
  end

  localparam logic [3:0] LP_RK_FIRST  = 4'(NUM_ROUNDS);
  localparam logic [3:0] LP_RND_START = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_e;

  state_e                r_fsm;
  state_e                w_fsm_nxt;
  logic                  w_accept;
  logic [3:0]            r_rnd;
  logic [DATA_WIDTH-1:0] r_block;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] w_mid;
  logic [DATA_WIDTH-1:0] w_last;

  inverse_round #(.LAST_ROUND(1'b0)) u_round_mid (.i_state(r_block), .i_rk(rk_data), .o_state(w_mid));
  inverse_round #(.LAST_ROUND(1'b1)) u_round_last (.i_state(r_block), .i_rk(rk_data), .o_state(w_last));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state logic; flush overrides every transition, including an acceptance.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_accept  = 1'b0;
    if (flush) begin
      w_fsm_nxt = S_IDLE;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          w_accept = in_valid & key_valid;
          if (w_accept) w_fsm_nxt = S_ROUND;
          else          w_fsm_nxt = S_IDLE;
        end
        S_ROUND: begin
          if (r_rnd == 4'd0) w_fsm_nxt = S_DONE;
          else               w_fsm_nxt = S_ROUND;
        end
        S_DONE: begin
          if (out_ready) w_fsm_nxt = S_IDLE;
          else           w_fsm_nxt = S_DONE;
        end
        default: w_fsm_nxt = S_IDLE;
      endcase
    end
  end

  // Key index and input ready depend only on state and counter, never on the handshakes.
  always_comb begin
    in_ready = 1'b0;
    rk_idx   = LP_RK_FIRST;
    case (r_fsm)
      S_IDLE:  in_ready = key_valid & rst_n;
      S_ROUND: rk_idx   = r_rnd;
      S_DONE:  rk_idx   = LP_RK_FIRST;
      default: rk_idx   = LP_RK_FIRST;
    endcase
  end

  // Datapath: initial whitening on acceptance, one round per cycle, last round lands in dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd   <= 4'd0;
      r_block <= '0;
      r_dout  <= '0;
    end else if (flush) begin
      r_rnd <= 4'd0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_block <= din ^ rk_data;
            r_rnd   <= LP_RND_START;
          end
        end
        S_ROUND: begin
          if (r_rnd != 4'd0) begin
            r_block <= w_mid;
            r_rnd   <= r_rnd - 4'd1;
          end else begin
            r_dout <= w_last;
          end
        end
        default: r_rnd <= r_rnd;
      endcase
    end
  end

  assign dout      = r_dout;
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm == S_ROUND) || (r_fsm == S_DONE);

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl: FIPS-197 vectors plus random plaintexts encrypted by a forward AES-128
// model, so each decryption is checked against the plaintext it came from.
module tb_aes_decipher_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic key_valid = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] din = '0;
  logic in_ready, out_valid, busy;
  logic [3:0] rk_idx;
  logic [127:0] rk_data, dout;

  logic [127:0] rk_tab [16];
  logic [7:0]   sbox [256];
  logic [127:0] src_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  int           acc_q[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rk_data = rk_tab[rk_idx];

  aes_decipher_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int y = 1; y < 256; y++)
      if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  task automatic build_sbox();
    logic [7:0] a;
    for (int x = 0; x < 256; x++) begin
      a = ginv(8'(x));
      sbox[x] = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]] ^ rcon, sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] n [16];
    logic [127:0] blk;
    blk = pt ^ rk_tab[0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[blk[8*(15-k) +: 8]];
      for (int k = 0; k < 16; k++) n[k] = s[(k % 4) + 4 * (((k / 4) + (k % 4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(n[4*c], 8'h02) ^ gmul(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+1] = n[4*c] ^ gmul(n[4*c+1], 8'h02) ^ gmul(n[4*c+2], 8'h03) ^ n[4*c+3];
          s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gmul(n[4*c+2], 8'h02) ^ gmul(n[4*c+3], 8'h03);
          s[4*c+3] = gmul(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gmul(n[4*c+3], 8'h02);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = n[4*c+j];
        end
      end
      for (int k = 0; k < 16; k++) blk[8*(15-k) +: 8] = s[k] ^ rk_tab[r][8*(15-k) +: 8];
    end
    return blk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block, wait for acceptance, then count cycles until out_valid (out_ready untouched).
  task automatic send_one(input logic [127:0] ct, output logic [127:0] got, output int lat);
    int w = 0;
    in_valid = 1'b1;
    din = ct;
    while (!in_ready && w < 50) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    got = dout;
  endtask

  // Stream src_q through the DUT with random valid/ready; records acceptance cycles and outputs.
  task automatic run_stream(input int v_pct, input int r_pct, input int max_cyc);
    int cyc = 0;
    int idx = 0;
    acc_q.delete();
    got_q.delete();
    in_valid = 1'b0;
    while (got_q.size() < src_q.size() && cyc < max_cyc) begin
      if (!in_valid && idx < src_q.size()) in_valid = ($urandom_range(0, 99) < v_pct);
      din = (idx < src_q.size()) ? src_q[idx] : '0;
      out_ready = ($urandom_range(0, 99) < r_pct);
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc);
        idx++;
        tick();
        in_valid = 1'b0;
      end else begin
        if (out_valid && out_ready) got_q.push_back(dout);
        tick();
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_valid = 1'b1;
    #12;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (dout !== 128'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (rk_idx !== 4'd10) begin n_fail++; $display("FAIL post_reset_rk_idx: got %0d want 10", rk_idx); end
  endtask

  task automatic test_fips_c1();
    int w = 0;
    int lat = 0;
    int seq[$];
    set_key(C1_KEY);
    out_ready = 1'b1;
    in_valid = 1'b1;
    din = C1_CT;
    while (!in_ready && w < 50) begin tick(); w++; end
    seq.push_back(int'(rk_idx));
    tick();
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin seq.push_back(int'(rk_idx)); tick(); lat++; end
    n_tests++; if (lat != 10) begin n_fail++; $display("FAIL c1_latency: got %0d want 10", lat); end
    n_tests++; if (dout !== C1_PT) begin n_fail++; $display("FAIL c1_dout: got %h want %h", dout, C1_PT); end
    n_tests++; if (seq.size() != 11) begin n_fail++; $display("FAIL c1_rk_seq_len: got %0d want 11", seq.size()); end
    for (int i = 0; i < seq.size() && i < 11; i++) begin
      n_tests++; if (seq[i] != 10 - i) begin n_fail++; $display("FAIL c1_rk_idx[%0d]: got %0d want %0d", i, seq[i], 10 - i); end
    end
    tick();
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL c1_after_hs: got out_valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_fips_b_stall();
    logic [127:0] got;
    int lat;
    set_key(B_KEY);
    out_ready = 1'b0;
    send_one(B_CT, got, lat);
    n_tests++; if (lat != 10) begin n_fail++; $display("FAIL b_latency: got %0d want 10", lat); end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (dout !== B_PT) begin n_fail++; $display("FAIL b_dout_stall%0d: got %h want %h", i, dout, B_PT); end
      n_tests++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL b_flags_stall%0d: got in_ready=%b busy=%b out_valid=%b want 0 1 1", i, in_ready, busy, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b_release: got busy=%b out_valid=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    set_key(C1_KEY);
    src_q = {C1_CT, encrypt(B_PT)};
    exp_q = {C1_PT, B_PT};
    run_stream(100, 100, 100);
    n_tests++; if (acc_q.size() != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", acc_q.size()); end
    else begin
      n_tests++; if (acc_q[1] - acc_q[0] != 12) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 12", acc_q[1] - acc_q[0]); end
    end
    n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_key_valid();
    int lat = 0;
    key_valid = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    din = C1_CT;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL kv_blocked%0d: got in_ready=%b busy=%b want 0 0", i, in_ready, busy); end
      tick();
    end
    key_valid = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kv_raise_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kv_accepted: got busy=%b want 1", busy); end
    while (!out_valid && lat < 40) begin tick(); lat++; end
    n_tests++; if (lat != 10 || dout !== C1_PT) begin n_fail++; $display("FAIL kv_result: got lat=%0d dout=%h want 10 %h", lat, dout, C1_PT); end
    tick();
  endtask

  task automatic test_flush();
    logic [127:0] d_before;
    logic [127:0] got;
    int w = 0;
    int lat;
    bit seen = 1'b0;
    out_ready = 1'b1;
    d_before = dout;
    in_valid = 1'b1;
    din = C1_CT;
    while (!in_ready && w < 50) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy=%b out_valid=%b want 0 0", busy, out_valid); end
    n_tests++; if (dout !== d_before) begin n_fail++; $display("FAIL flush_dout_kept: got %h want %h", dout, d_before); end
    repeat (15) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL flush_no_output: got out_valid seen=1 want 0"); end
    send_one(C1_CT, got, lat);
    n_tests++; if (lat != 10 || got !== C1_PT) begin n_fail++; $display("FAIL flush_reissue: got lat=%0d dout=%h want 10 %h", lat, got, C1_PT); end
    tick();
  endtask

  task automatic test_async_reset();
    logic [127:0] got;
    int w = 0;
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    din = C1_CT;
    while (!in_ready && w < 50) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || dout !== 128'h0) begin
      n_fail++; $display("FAIL arst_immediate: got out_valid=%b busy=%b dout=%h want 0 0 0", out_valid, busy, dout);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release_ready: got %b want 1", in_ready); end
    send_one(C1_CT, got, lat);
    n_tests++; if (lat != 10 || got !== C1_PT) begin n_fail++; $display("FAIL arst_redo: got lat=%0d dout=%h want 10 %h", lat, got, C1_PT); end
    tick();
  endtask

  task automatic test_random_stream();
    logic [127:0] pt;
    set_key({$urandom, $urandom, $urandom, $urandom});
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(pt);
      src_q.push_back(encrypt(pt));
    end
    run_stream(60, 50, 1500);
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_dout[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    build_sbox();
    set_key(C1_KEY);
    test_reset();
    test_fips_c1();
    test_fips_b_stall();
    test_back_to_back();
    test_key_valid();
    test_flush();
    test_async_reset();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
